bht_update_queue: RTL and testbench
===================================

Name: bht_update_queue

Overview:
- Upstream feeder for the branch history table: buffers resolved-branch results from EX and drains them into the BHT counter-update port, one per cycle.
- Owns the committed global history register (GHR) and computes the gshare table index for each update, so the BHT only applies saturating-counter arithmetic.
- Decouples EX resolution bursts from BHT write availability.

Parameters:
- DEPTH, 128, BHT entry count, power of 2; IDX_W = log2(DEPTH).
- G_DEPTH, 4, GHR width in bits, 1 <= G_DEPTH <= IDX_W.
- Q_DEPTH, 4, queue entries, power of 2, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- res_valid  input  1  EX presents a resolved conditional branch.
- res_ready  output  1  queue accepts; equals !full.
- res_pc  input  32  branch PC.
- res_taken  input  1  resolved direction.
- flush  input  1  pipeline flush; discards all queued entries.
- upd_valid  output  1  head entry available to the BHT.
- upd_ready  input  1  BHT accepts the update this cycle.
- upd_idx  output  IDX_W  gshare index: res_pc[IDX_W+1:2] XOR zero-extended ghr.
- upd_taken  output  1  head entry direction.
- upd_pc  output  32  head entry PC, for debug and tag use.
- ghr  output  G_DEPTH  committed global history.

Behaviour:
- Reset (async, reset_n=0): read/write pointers = 0, count = 0, ghr = 0. Outputs: upd_valid=0, res_ready=1, upd_idx=0, upd_taken=0, upd_pc=0. Entry storage is not reset; outputs are masked while empty.
- Storage: circular buffer of Q_DEPTH entries {pc[31:0], taken}. Pointers are log2(Q_DEPTH) bits and wrap modulo Q_DEPTH. Count is log2(Q_DEPTH)+1 bits.
- Enqueue: res_valid && res_ready writes the entry at wptr and increments wptr and count.
- Dequeue: upd_valid && upd_ready increments rptr, decrements count, and shifts the GHR: ghr <= {ghr[G_DEPTH-2:0], upd_taken}. For G_DEPTH=1, ghr <= upd_taken.
- upd_valid = (count != 0) && !flush.
- upd_idx, upd_taken and upd_pc are combinational from the head entry and the current ghr (the value before the shift on a dequeue).
- Latency: an entry enqueued at edge N is visible at the head (upd_valid=1) in the cycle after edge N. There is no same-cycle bypass.
- Full (count == Q_DEPTH): res_ready=0, and res_valid is ignored even if a dequeue happens in the same cycle. The slot frees one cycle later.
- Simultaneous enqueue and dequeue when not full: count unchanged, both pointers advance.
- Empty: upd_valid=0 regardless of upd_ready. ghr holds.
- Flush (synchronous, one cycle):
  - Next state has pointers = 0 and count = 0.
  - An enqueue presented in the flush cycle is dropped.
  - upd_valid is forced to 0, so no dequeue occurs and ghr does not shift.
  - ghr is preserved across flush, because it holds only committed history.
  - res_ready stays !full during flush.
- Reset mid-operation: immediate clear to the reset state; no update is emitted.
- Ordering: strict FIFO. Updates reach the BHT in resolution order, so every index uses history from all older branches.

Test Plan:
- Single branch: after reset, res_pc=0x0000_0104, taken=1, upd_ready=1 → upd_valid asserts the next cycle with upd_idx=0x41 and ghr=0. After the dequeue edge, ghr=4'b0001 and upd_valid=0.
- Back-pressure/full: upd_ready=0, enqueue 5 consecutive branches with Q_DEPTH=4 → res_ready drops after the 4th accept and the 5th is held off. Raising upd_ready drains all 4 in order on consecutive cycles, and res_ready=1 one cycle after the first dequeue.
- Gshare index: ghr preloaded to 4'b1011 via taken pattern 1,0,1,1; next pc=0x0000_0104 → upd_idx = 0x41 ^ 0x0B = 0x4A.
- Concurrent enqueue/dequeue at count=2 over 8 cycles → count stays 2, pointers wrap past Q_DEPTH-1 to 0, and the output order matches the input order.
- Flush with 3 entries queued, ghr=4'b0110, and res_valid=1 in the flush cycle → upd_valid=0 in the flush cycle and afterwards, count=0, the new entry is dropped, and ghr stays 4'b0110.
- Async reset asserted mid-drain → upd_valid=0, res_ready=1 and ghr=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bht_update_queue.sv
// bht_update_queue: FIFO of resolved branches feeding BHT counter updates, owning the committed GHR and gshare index.
module bht_update_queue #(
  parameter int DEPTH   = 128,
  parameter int G_DEPTH = 4,
  parameter int Q_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [31:0]              res_pc,
  input  logic                     res_taken,
  input  logic                     flush,
  output logic                     upd_valid,
  input  logic                     upd_ready,
  output logic [$clog2(DEPTH)-1:0] upd_idx,
  output logic                     upd_taken,
  output logic [31:0]              upd_pc,
  output logic [G_DEPTH-1:0]       ghr
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int P_W   = $clog2(Q_DEPTH);
  logic [31:0]      pc_mem    [Q_DEPTH];
  logic             taken_mem [Q_DEPTH];
  logic [P_W-1:0]   wptr, rptr;
  logic [P_W:0]     count;
  logic [G_DEPTH-1:0] ghr_next;
  logic empty, enq, deq;
  assign empty     = count == '0;
  assign res_ready = count != (P_W+1)'(Q_DEPTH);
  assign upd_valid = !empty && !flush;
  assign enq       = res_valid && res_ready && !flush;
  assign deq       = upd_valid && upd_ready;
  assign upd_pc    = empty ? '0 : pc_mem[rptr];
  assign upd_taken = empty ? 1'b0 : taken_mem[rptr];
  // head index uses history before this update's own shift
  assign upd_idx   = empty ? '0 : upd_pc[IDX_W+1:2] ^ IDX_W'(ghr);
  generate
    if (G_DEPTH == 1) begin : g_one
      assign ghr_next = upd_taken;
    end else begin : g_many
      assign ghr_next = {ghr[G_DEPTH-2:0], upd_taken};
    end
  endgenerate
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      count <= count + (P_W+1)'(enq) - (P_W+1)'(deq);
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ghr <= '0;
    else if (deq) ghr <= ghr_next;
  always_ff @(posedge clk)
    if (enq) begin
      pc_mem[wptr]    <= res_pc;
      taken_mem[wptr] <= res_taken;
    end
endmodule

// File: tb/tb_bht_update_queue.sv
// tb_bht_update_queue: directed scoreboard bench for the BHT update queue.
module tb_bht_update_queue;
  logic clk = 0, reset_n = 0;
  logic res_valid = 0, res_taken = 0, flush = 0, upd_ready = 0;
  logic [31:0] res_pc = 0;
  logic res_ready, upd_valid, upd_taken;
  logic [6:0] upd_idx;
  logic [31:0] upd_pc;
  logic [3:0] ghr;
  typedef struct { logic [31:0] pc; logic t; } ent_t;
  ent_t q[$];
  ent_t e;
  logic [3:0] mghr = 0;
  int errors = 0, checks = 0;
  bht_update_queue dut (.clk(clk), .reset_n(reset_n), .res_valid(res_valid), .res_ready(res_ready),
    .res_pc(res_pc), .res_taken(res_taken), .flush(flush), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pc(upd_pc), .ghr(ghr));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic t, input logic r, input logic f);
    res_valid = v; res_pc = pc; res_taken = t; upd_ready = r; flush = f;
  endtask
  // check the cycle against the model, then advance one clock to the next negedge
  task automatic tick();
    logic ev;
    #1;
    ev = q.size() != 0 && !flush;
    chk("ghr", ghr, mghr);
    chk("upd_valid", upd_valid, ev);
    chk("res_ready", res_ready, q.size() < 4);
    if (ev && upd_ready) begin
      e = q.pop_front();
      chk("upd_pc", upd_pc, e.pc);
      chk("upd_taken", upd_taken, e.t);
      chk("upd_idx", upd_idx, e.pc[8:2] ^ {3'b0, mghr});
      mghr = {mghr[2:0], e.t};
    end
    if (flush) q.delete();
    else if (res_valid && q.size() < 4) q.push_back('{res_pc, res_taken});
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic pattern(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) begin drive(1, 32'h200 + 32'(i) * 4, bits[i], 1, 0); tick(); end
    drive(0, 0, 0, 1, 0); tick(); tick();
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_res_ready", res_ready, 1);
    chk("rst_upd_idx", upd_idx, 0);
    chk("rst_upd_taken", upd_taken, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_ghr", ghr, 0);
    @(negedge clk);
    reset_n = 1;
    // single branch
    drive(1, 32'h104, 1, 1, 0); tick();
    drive(0, 0, 0, 1, 0);
    #1;
    chk("single_valid", upd_valid, 1);
    chk("single_idx", upd_idx, 7'h41);
    chk("single_ghr0", ghr, 0);
    tick();
    #1;
    chk("single_ghr1", ghr, 4'b0001);
    chk("single_empty", upd_valid, 0);
    // back-pressure to full, fifth held off, then drain
    for (int i = 0; i < 5; i++) begin drive(1, 32'h1000 + 32'(i) * 4, i[0], 0, 0); tick(); end
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick();
    // gshare index with preloaded history
    pattern(4'b1011);
    chk("gs_ghr", ghr, 4'b1011);
    drive(1, 32'h104, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0);
    #1;
    chk("gs_idx", upd_idx, 7'h4A);
    tick(); tick();
    // concurrent enqueue/dequeue at count=2, wrapping pointers
    for (int i = 0; i < 2; i++) begin drive(1, 32'h2000 + 32'(i) * 4, 1, 0, 0); tick(); end
    for (int i = 0; i < 8; i++) begin drive(1, 32'h3000 + 32'(i) * 8, i[1], 1, 0); tick(); end
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    // flush with three queued entries and a dropped enqueue
    pattern(4'b0110);
    for (int i = 0; i < 3; i++) begin drive(1, 32'h4000 + 32'(i) * 4, 1, 0, 0); tick(); end
    drive(1, 32'h5000, 1, 1, 1); tick();
    drive(0, 0, 0, 1, 0); tick(); tick();
    chk("flush_ghr", ghr, 4'b0110);
    // async reset mid-drain
    for (int i = 0; i < 3; i++) begin drive(1, 32'h6000 + 32'(i) * 4, 1, 0, 0); tick(); end
    drive(0, 0, 0, 1, 0); tick();
    #2 reset_n = 0;
    #1;
    chk("arst_upd_valid", upd_valid, 0);
    chk("arst_res_ready", res_ready, 1);
    chk("arst_ghr", ghr, 0);
    q.delete();
    mghr = 0;
    @(negedge clk);
    reset_n = 1;
    drive(1, 32'h7008, 1, 1, 0); tick();
    drive(0, 0, 0, 1, 0); tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
